// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int TIMER_W = 8;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline stages and register controls back to them.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_branch_taken;
  logic             ex_prediction;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             redirect;
  logic             redirect_taken;
  logic             mem_err;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_freeze_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  // Pipeline side: reports stage status, receives controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch, ex_jump, ex_branch_taken, ex_prediction, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_wb_bubble, redirect, redirect_taken, mem_err,
           perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch, ex_jump, ex_branch_taken, ex_prediction, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
           id_ex_flush, mem_wb_bubble, redirect, redirect_taken, mem_err,
           perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use comparator; also reused by the forwarding unit.
module load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Merges load-use, mispredict and MEM-wait hazards into pipeline register controls.
// Optional performance counters are built when PIPELINE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MEM_TIMEOUT);

  state_t               state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic                 mem_err_reg;
  logic                 freeze;
  logic                 mispredict;
  logic                 load_use;

  assign freeze     = bus.mem_req & ~bus.mem_ready;
  assign mispredict = (bus.ex_branch & (bus.ex_branch_taken != bus.ex_prediction)) |
                      (bus.ex_jump & ~bus.ex_prediction);

  load_use_detect u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      timer_reg   <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (state_next == HALT) mem_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      RUN: begin
        if (freeze) begin
          state_next = MEM_WAIT;
          timer_next = TIMER_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_next = RUN;
        end else if (timer_reg >= TIMEOUT_VAL) begin
          state_next = HALT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Priority: reset, HALT, freeze, mispredict, load-use. Nothing is latched,
  // so a condition masked by freeze is simply seen again on the release cycle.
  always_comb begin
    bus.pc_write       = 1'b1;
    bus.if_id_write    = 1'b1;
    bus.id_ex_write    = 1'b1;
    bus.ex_mem_write   = 1'b1;
    bus.if_id_flush    = 1'b0;
    bus.id_ex_flush    = 1'b0;
    bus.mem_wb_bubble  = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_taken = 1'b0;
    if (!rst_n) begin
      {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write} = 4'b0000;
      {bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble} = 3'b111;
    end else if (state_reg == HALT || freeze) begin
      {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write} = 4'b0000;
      bus.mem_wb_bubble = 1'b1;
    end else if (mispredict) begin
      bus.redirect       = 1'b1;
      bus.redirect_taken = bus.ex_branch_taken | bus.ex_jump;
      bus.if_id_flush    = 1'b1;
      bus.id_ex_flush    = 1'b1;
    end else if (load_use) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  assign bus.mem_err = mem_err_reg;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic       run_ok;
  logic [2:0] cnt_inc;

  assign run_ok     = rst_n & (state_reg != HALT) & ~freeze;
  assign cnt_inc[0] = run_ok & ~mispredict & load_use;
  assign cnt_inc[1] = rst_n & ((state_reg == HALT) | freeze);
  assign cnt_inc[2] = run_ok & mispredict;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && cnt_reg != {CNT_W{1'b1}}) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.perf_stall_cnt  = g_cnt[0].cnt_reg;
  assign bus.perf_freeze_cnt = g_cnt[1].cnt_reg;
  assign bus.perf_flush_cnt  = g_cnt[2].cnt_reg;
`else
  assign bus.perf_stall_cnt  = '0;
  assign bus.perf_freeze_cnt = '0;
  assign bus.perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl (MEM_TIMEOUT = 4).
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctrl bit order: pc_write if_id_write id_ex_write ex_mem_write
  //                 if_id_flush id_ex_flush mem_wb_bubble redirect redirect_taken mem_err
  localparam logic [9:0] C_NORMAL   = 10'b1111_000_00_0;
  localparam logic [9:0] C_LOADUSE  = 10'b0011_010_00_0;
  localparam logic [9:0] C_MISP_NT  = 10'b1111_110_10_0;
  localparam logic [9:0] C_MISP_T   = 10'b1111_110_11_0;
  localparam logic [9:0] C_FREEZE   = 10'b0000_001_00_0;
  localparam logic [9:0] C_HALT     = 10'b0000_001_00_1;
  localparam logic [9:0] C_RST      = 10'b0000_111_00_0;
  localparam logic [9:0] C_RST_ERR  = 10'b0000_111_00_1;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [9:0] ctrl;
  assign ctrl = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                 bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble,
                 bus.redirect, bus.redirect_taken, bus.mem_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0;          bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0;     bus.id_uses_rs2 = 1'b0;
    bus.ex_mem_read = 1'b0;     bus.ex_rd = 5'd0;
    bus.ex_branch = 1'b0;       bus.ex_jump = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.ex_prediction = 1'b0;
    bus.mem_req = 1'b0;         bus.mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check(tag, 32'(ctrl), 32'(exp));
  endtask

  task automatic chk_cnt(input int stall, input int frz, input int flush);
    check("perf_stall", bus.perf_stall_cnt, PERF ? 32'(stall) : 32'd0);
    check("perf_freeze", bus.perf_freeze_cnt, PERF ? 32'(frz) : 32'd0);
    check("perf_flush", bus.perf_flush_cnt, PERF ? 32'(flush) : 32'd0);
  endtask

  task automatic set_load_use_rs2(input logic [4:0] rd);
    bus.ex_mem_read = 1'b1; bus.ex_rd = rd;
    bus.id_rs2 = 5'd5;      bus.id_uses_rs2 = 1'b1;
  endtask

  task automatic set_mispredict_nt();
    bus.ex_branch = 1'b1; bus.ex_branch_taken = 1'b0; bus.ex_prediction = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    chk("reset_forced", C_RST);
    chk_cnt(0, 0, 0);

    next_cycle(); rst_n = 1'b1;
    chk("idle", C_NORMAL);

    // Load-use on rs2: exactly one stall cycle.
    next_cycle(); set_load_use_rs2(5'd5);
    chk("load_use_rs2", C_LOADUSE);
    next_cycle(); idle();
    chk("load_use_clear", C_NORMAL);
    chk_cnt(1, 0, 0);

    next_cycle(); set_load_use_rs2(5'd0);
    chk("load_use_x0", C_NORMAL);

    next_cycle(); idle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1;
    chk("load_use_rs1", C_LOADUSE);
    next_cycle(); bus.id_uses_rs1 = 1'b0;
    chk("load_use_unused", C_NORMAL);

    // Mispredicts.
    next_cycle(); idle(); set_mispredict_nt();
    chk("misp_branch_nt", C_MISP_NT);
    next_cycle(); idle(); bus.ex_jump = 1'b1; bus.ex_prediction = 1'b0;
    chk("misp_jump", C_MISP_T);
    next_cycle(); idle();
    bus.ex_branch = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_prediction = 1'b1;
    chk("branch_correct", C_NORMAL);
    chk_cnt(2, 0, 2);

    // Three frozen cycles, release on the fourth.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      chk("freeze", C_FREEZE);
    end
    next_cycle(); bus.mem_ready = 1'b1;
    chk("freeze_release", C_NORMAL);
    next_cycle(); idle();
    chk("after_release", C_NORMAL);
    chk_cnt(2, 3, 2);

    // Freeze masks mispredict and load-use; mispredict wins on release.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); idle(); set_mispredict_nt(); set_load_use_rs2(5'd5);
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      chk("freeze_combo", C_FREEZE);
    end
    next_cycle(); bus.mem_ready = 1'b1;
    chk("combo_release", C_MISP_NT);
    next_cycle(); idle();
    chk("combo_after", C_NORMAL);
    chk_cnt(2, 5, 3);

    // Timeout: 5 not-ready cycles, HALT visible on the 6th.
    for (int i = 0; i < 5; i++) begin
      next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      chk("timeout_wait", C_FREEZE);
    end
    next_cycle();
    chk("halt_entry", C_HALT);
    next_cycle(); idle(); bus.mem_ready = 1'b1;
    chk("halt_sticky", C_HALT);
    chk_cnt(2, 11, 3);

    next_cycle(); rst_n = 1'b0;
    chk("halt_reset_low", C_RST_ERR);
    next_cycle(); rst_n = 1'b1; idle();
    chk("post_reset", C_NORMAL);
    chk_cnt(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It merges three stall/flush sources into one consistent set of pipeline-register enables and flushes:
- load-use data hazards detected in ID;
- branch/jump mispredictions resolved in EX;
- multi-cycle data-memory accesses in MEM, with a ready handshake and timeout.

It sits beside the decode-stage control unit and drives the write/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- MEM_TIMEOUT, 16, consecutive not-ready MEM cycles tolerated before fatal halt; legal range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jump  in  1  EX instruction is a jump.
- ex_branch_taken  in  1  branch outcome resolved in EX.
- ex_prediction  in  1  predicted-taken bit carried with the EX instruction.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the MEM access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  insert a bubble into that register.
- redirect  out  1  PC takes the EX-computed correction target this cycle.
- redirect_taken  out  1  correction is the taken target (1) or the fall-through PC+4 (0).
- mem_err  out  1  sticky timeout error.
- perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt  out  32 each  performance counters.

## Operation
- States are RUN, MEM_WAIT and HALT. A 8-bit wait timer tracks MEM_WAIT.
- freeze = mem_req & !mem_ready. In RUN and MEM_WAIT, freeze has the highest priority. When freeze is high:
  - all four write enables are 0;
  - mem_wb_bubble = 1;
  - no flush and no redirect.
- mispredict = (ex_branch & (ex_branch_taken != ex_prediction)) | (ex_jump & !ex_prediction). It applies when freeze is low and has second priority:
  - redirect = 1;
  - redirect_taken = ex_branch_taken | ex_jump;
  - if_id_flush = 1 and id_ex_flush = 1;
  - all write enables are 1.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)). It applies with no freeze and no mispredict, and has third priority:
  - pc_write = 0 and if_id_write = 0;
  - id_ex_flush = 1;
  - id_ex_write = 1 and ex_mem_write = 1.
- If none of the three conditions holds: all enables are 1, all flushes/bubbles are 0, and redirect = 0.
- State transitions:
  - RUN & freeze → MEM_WAIT, with timer ← 1.
  - MEM_WAIT & mem_ready → RUN. The release happens in the same cycle: outputs follow the normal priority evaluation in that cycle.
  - MEM_WAIT & !mem_ready & timer == MEM_TIMEOUT → HALT.
  - MEM_WAIT & !mem_ready & timer < MEM_TIMEOUT → timer ← timer + 1.
  - HALT persists until reset.
- In HALT: all enables are 0, mem_wb_bubble = 1, mem_err = 1.
- A freeze coinciding with a mispredict or load-use suppresses both. EX/ID are held, so the condition is re-evaluated on the release cycle; nothing is latched.
- A load-use that coincides with a mispredict produces no stall; the ID instruction is wrong-path and is flushed.

## Timing
- All hazard outputs are combinational from the inputs and state; the only sequential elements are state, timer, mem_err and the counters.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM, so the condition clears without extra state.
- Mispredict costs 1 redirect cycle and 2 flushed slots.
- Timeout is reached after MEM_TIMEOUT+1 consecutive not-ready cycles (the RUN entry cycle plus MEM_TIMEOUT cycles in MEM_WAIT). HALT and mem_err are visible on the following cycle.
- Reset (rst_n low at a rising edge), including mid-MEM_WAIT or in HALT:
  - next state is RUN; timer, mem_err and the counters are cleared.
  - while rst_n is low, the outputs are forced: all enables 0, if_id_flush = id_ex_flush = mem_wb_bubble = 1, redirect = 0.

## Configuration
- PIPELINE_CTRL_PERF_CNT_EN defined:
  - perf_stall_cnt increments on each load-use stall cycle;
  - perf_freeze_cnt increments on each freeze or HALT cycle;
  - perf_flush_cnt increments on each mispredict cycle;
  - each counter is 32-bit, saturates at 0xFFFFFFFF, and is cleared by reset.
- PIPELINE_CTRL_PERF_CNT_EN undefined: no counter flops are built; the three ports remain and are driven by constant 0.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - the timer width constant (8);
  - the counter width constant (32).
- One sub-module, load_use_detect: the purely combinational load_use comparator, reused by the forwarding unit.

## Test plan
- ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 for one cycle → pc_write = 0, if_id_write = 0, id_ex_flush = 1 for exactly that cycle; perf_stall_cnt = 1.
- Same as above but ex_rd = 0 → no stall; all enables 1.
- ex_branch = 1, ex_branch_taken = 0, ex_prediction = 1 → redirect = 1, redirect_taken = 0, if_id_flush = id_ex_flush = 1; perf_flush_cnt = 1.
- mem_req = 1 with mem_ready low for 3 cycles, then high → 3 frozen cycles with mem_wb_bubble = 1; release in the 4th cycle; state back to RUN; mem_err = 0.
- MEM_TIMEOUT = 4, mem_req = 1, mem_ready held low → after 5 not-ready cycles, HALT and mem_err = 1 in cycle 6; both stay high; rst_n low for one edge clears them.
- Freeze plus mispredict plus load-use all high for 2 cycles, then mem_ready = 1 → no redirect during the freeze; redirect = 1 on the release cycle and no stall.
